// File: rtl/bubble_shooter_ctrl.sv
// bubble_shooter_ctrl: turns raw PmodJSTK data into a saturating column cursor
// (shoot_pos) and a one-clock fire pulse (jstkPress). The trigger is
// synchronized and debounced, and a fire/cooldown/release FSM guarantees one
// pulse per physical press. The cursor is frozen while a shot is in flight.
module bubble_shooter_ctrl #(
  parameter logic [9:0] DZ_LO          = 10'd300,
  parameter logic [9:0] DZ_HI          = 10'd700,
  parameter int         DEBOUNCE_CYC   = 16,
  parameter int         COOLDOWN_TICKS = 2,
  parameter int         NUM_COLS       = 8,
  parameter int         START_COL      = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       dclk,
  input  logic [9:0] jstk_x,
  input  logic       jstk_btn,
  output logic [2:0] shoot_pos,
  output logic       jstkPress,
  output logic       ready,
  output logic [7:0] fire_cnt
);

  localparam int              DB_W      = $clog2(DEBOUNCE_CYC) + 1;
  localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [2:0]      COL_MAX   = 3'(NUM_COLS - 1);
  localparam logic [2:0]      COL_START = 3'(START_COL);
  localparam logic [3:0]      COOL_LOAD = 4'(COOLDOWN_TICKS);

  typedef enum logic [1:0] {
    READY        = 2'd0,
    FIRE         = 2'd1,
    COOLDOWN     = 2'd2,
    WAIT_RELEASE = 2'd3
  } state_t;

  state_t          state_reg, state_next;
  logic            prev_dclk_reg;
  logic [1:0]      sync_reg;
  logic            btn_stable_reg;
  logic            btn_prev_stable_reg;
  logic [DB_W-1:0] db_cnt_reg;
  logic [3:0]      cool_cnt_reg, cool_cnt_next;
  logic [2:0]      pos_reg, pos_next;
  logic [7:0]      fire_cnt_reg, fire_cnt_next;

  logic tick;
  logic press_edge;
  logic cursor_live;

  // One-clock strobe per rising edge of the slow tick.
  assign tick = dclk & ~prev_dclk_reg;

  // Debounced rising edge of the trigger.
  assign press_edge = btn_stable_reg & ~btn_prev_stable_reg;

  // The cursor may only move outside of a shot in flight.
  assign cursor_live = (state_reg == READY) || (state_reg == WAIT_RELEASE);

  // Remember the previous dclk level for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_dclk_reg <= 1'b0;
    end else begin
      prev_dclk_reg <= dclk;
    end
  end

  // Two-flop synchronizer feeding a persistence counter; the accepted level
  // flips only after the mismatch has held for DEBOUNCE_CYC cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_reg            <= 2'b00;
      btn_stable_reg      <= 1'b0;
      btn_prev_stable_reg <= 1'b0;
      db_cnt_reg          <= '0;
    end else begin
      sync_reg            <= {sync_reg[0], jstk_btn};
      btn_prev_stable_reg <= btn_stable_reg;
      if (sync_reg[1] != btn_stable_reg) begin
        if (db_cnt_reg == DB_LAST) begin
          btn_stable_reg <= ~btn_stable_reg;
          db_cnt_reg     <= '0;
        end else begin
          db_cnt_reg <= db_cnt_reg + 1'b1;
        end
      end else begin
        db_cnt_reg <= '0;
      end
    end
  end

  // Next-state, cooldown counter and shot counter for the fire FSM.
  always_comb begin
    state_next    = state_reg;
    cool_cnt_next = cool_cnt_reg;
    fire_cnt_next = fire_cnt_reg;
    case (state_reg)
      READY: begin
        if (en && press_edge) begin
          state_next = FIRE;
        end
      end
      FIRE: begin
        state_next    = COOLDOWN;
        cool_cnt_next = COOL_LOAD;
        if (fire_cnt_reg != 8'hFF) begin
          fire_cnt_next = fire_cnt_reg + 8'd1;
        end
      end
      COOLDOWN: begin
        if (tick) begin
          // A zero count can only arise from an illegal parameter; treat it
          // like the last tick so the FSM can never stall here.
          if (cool_cnt_reg <= 4'd1) begin
            cool_cnt_next = 4'd0;
            state_next    = btn_stable_reg ? WAIT_RELEASE : READY;
          end else begin
            cool_cnt_next = cool_cnt_reg - 4'd1;
          end
        end
      end
      WAIT_RELEASE: begin
        if (!btn_stable_reg) begin
          state_next = READY;
        end
      end
      default: begin
        state_next = READY;
      end
    endcase
  end

  // Saturating one-column-per-tick cursor movement outside the dead zone.
  always_comb begin
    pos_next = pos_reg;
    if (tick && en && cursor_live) begin
      if (jstk_x < DZ_LO) begin
        if (pos_reg != 3'd0) begin
          pos_next = pos_reg - 3'd1;
        end
      end else if (jstk_x > DZ_HI) begin
        if (pos_reg != COL_MAX) begin
          pos_next = pos_reg + 3'd1;
        end
      end
    end
  end

  // State, cooldown, shot count and cursor registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= READY;
      cool_cnt_reg <= 4'd0;
      fire_cnt_reg <= 8'd0;
      pos_reg      <= COL_START;
    end else begin
      state_reg    <= state_next;
      cool_cnt_reg <= cool_cnt_next;
      fire_cnt_reg <= fire_cnt_next;
      pos_reg      <= pos_next;
    end
  end

  assign shoot_pos = pos_reg;
  assign jstkPress = (state_reg == FIRE);
  assign ready     = (state_reg == READY);
  assign fire_cnt  = fire_cnt_reg;

endmodule

// File: tb/tb_bubble_shooter_ctrl.sv
// tb_bubble_shooter_ctrl: directed scenarios plus randomized segments, each
// cycle compared against a behavioural model of the shooter controller.
module tb_bubble_shooter_ctrl;

  localparam int DEB    = 16;
  localparam int COOL   = 2;
  localparam int LO     = 300;
  localparam int HI     = 700;
  localparam int MAXCOL = 7;
  localparam int START  = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b1;
  logic       dclk = 1'b0;
  logic [9:0] jstk_x = 10'd512;
  logic       jstk_btn = 1'b0;
  logic [2:0] shoot_pos;
  logic       jstkPress;
  logic       ready;
  logic [7:0] fire_cnt;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int dc_cnt = 0;
  int dc_half = 3;

  // Behavioural model state
  int  m_pos = START;
  int  m_shots = 0;
  int  m_cool_left = 0;
  bit  m_firing = 0;
  bit  m_need_release = 0;
  bit  m_stable = 0;
  bit  m_prev_stable = 0;
  bit  m_prev_dclk = 0;
  bit  m_sync0 = 0;
  bit  m_sync1 = 0;
  bit  hist[$];

  bubble_shooter_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .dclk     (dclk),
    .jstk_x   (jstk_x),
    .jstk_btn (jstk_btn),
    .shoot_pos(shoot_pos),
    .jstkPress(jstkPress),
    .ready    (ready),
    .fire_cnt (fire_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_step();
    bit tick, idle, fire_n, stable_n, need_n, s;
    int pos_n, shots_n, cool_n;
    if (rst) begin
      m_pos = START; m_shots = 0; m_cool_left = 0; m_firing = 0;
      m_need_release = 0; m_stable = 0; m_prev_stable = 0;
      m_prev_dclk = 0; m_sync0 = 0; m_sync1 = 0; hist.delete();
      return;
    end
    tick    = dclk && !m_prev_dclk;
    idle    = !m_firing && (m_cool_left == 0) && !m_need_release;
    pos_n   = m_pos;
    if (tick && en && !m_firing && m_cool_left == 0) begin
      if (int'(jstk_x) < LO)      pos_n = (m_pos > 0) ? m_pos - 1 : 0;
      else if (int'(jstk_x) > HI) pos_n = (m_pos < MAXCOL) ? m_pos + 1 : MAXCOL;
    end
    fire_n  = idle && en && m_stable && !m_prev_stable;
    shots_n = m_shots;
    cool_n  = m_cool_left;
    need_n  = m_need_release;
    if (m_firing) begin
      shots_n = (m_shots < 255) ? m_shots + 1 : 255;
      cool_n  = COOL;
    end else if (m_cool_left > 0) begin
      if (tick) begin
        cool_n = m_cool_left - 1;
        if (cool_n == 0) need_n = m_stable;
      end
    end else if (m_need_release && !m_stable) begin
      need_n = 0;
    end
    // Accept a new button level once DEB consecutive samples disagree.
    stable_n = m_stable;
    s = m_sync1;
    if (s == m_stable) hist.delete();
    else begin
      hist.push_back(s);
      if (hist.size() >= DEB) begin
        stable_n = !m_stable;
        hist.delete();
      end
    end
    m_prev_stable  = m_stable;
    m_stable       = stable_n;
    m_sync1        = m_sync0;
    m_sync0        = jstk_btn;
    m_prev_dclk    = dclk;
    m_pos          = pos_n;
    m_shots        = shots_n;
    m_cool_left    = cool_n;
    m_need_release = need_n;
    m_firing       = fire_n;
  endtask

  // One clock: drive inputs, let the edge happen, then compare outputs.
  task automatic cycle(input logic [9:0] x, input logic b, input logic e, input logic r);
    dc_cnt++;
    if (dc_cnt >= dc_half) begin
      dclk    = ~dclk;
      dc_cnt  = 0;
      dc_half = $urandom_range(2, 5);
    end
    jstk_x   = x;
    jstk_btn = b;
    en       = e;
    rst      = r;
    @(posedge clk);
    model_step();
    #1;
    check("shoot_pos", 32'(shoot_pos), 32'(m_pos));
    check("jstkPress", 32'(jstkPress), 32'(m_firing));
    check("ready", 32'(ready), 32'(!m_firing && m_cool_left == 0 && !m_need_release));
    check("fire_cnt", 32'(fire_cnt), 32'(m_shots));
    if (jstkPress === 1'b1) pulses++;
  endtask

  task automatic run(input int n, input logic [9:0] x, input logic b, input logic e);
    for (int i = 0; i < n; i++) cycle(x, b, e, 1'b0);
  endtask

  function automatic logic [9:0] pick_x();
    case ($urandom_range(0, 8))
      0: return 10'd100;
      1: return 10'd299;
      2: return 10'd300;
      3: return 10'd301;
      4: return 10'd512;
      5: return 10'd699;
      6: return 10'd700;
      7: return 10'd701;
      default: return 10'($urandom_range(0, 1023));
    endcase
  endfunction

  initial begin
    int p0;
    bit seen;
    // 1: reset, centred stick
    for (int i = 0; i < 3; i++) cycle(10'd512, 1'b0, 1'b1, 1'b1);
    check("reset_pos", 32'(shoot_pos), 32'd3);
    check("reset_ready", 32'(ready), 32'd1);
    check("reset_cnt", 32'(fire_cnt), 32'd0);
    run(60, 10'd512, 1'b0, 1'b1);
    check("centre_hold", 32'(shoot_pos), 32'd3);
    check("centre_nopulse", 32'(pulses), 32'd0);

    // 2: saturate left then right
    run(70, 10'd100, 1'b0, 1'b1);
    check("sat_left", 32'(shoot_pos), 32'd0);
    run(120, 10'd1000, 1'b0, 1'b1);
    check("sat_right", 32'(shoot_pos), 32'd7);

    // 3: glitch, then a real press
    run(10, 10'd512, 1'b1, 1'b1);
    run(30, 10'd512, 1'b0, 1'b1);
    check("glitch_nopulse", 32'(pulses), 32'd0);
    run(40, 10'd512, 1'b1, 1'b1);
    check("press_one", 32'(pulses), 32'd1);
    check("press_cnt", 32'(fire_cnt), 32'd1);
    check("held_notready", 32'(ready), 32'd0);
    run(60, 10'd512, 1'b0, 1'b1);
    check("release_ready", 32'(ready), 32'd1);

    // 4: hold through cooldown, release, press again
    pulses = 0;
    run(80, 10'd512, 1'b1, 1'b1);
    check("hold_one", 32'(pulses), 32'd1);
    check("hold_wait", 32'(ready), 32'd0);
    run(40, 10'd512, 1'b0, 1'b1);
    check("hold_release", 32'(ready), 32'd1);
    run(40, 10'd512, 1'b1, 1'b1);
    run(60, 10'd512, 1'b0, 1'b1);
    check("second_cnt", 32'(fire_cnt), 32'd3);

    // 5: cursor frozen during fire/cooldown while pushing left
    run(40, 10'd1000, 1'b0, 1'b1);
    seen = 0;
    p0 = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      cycle(10'd100, 1'b1, 1'b1, 1'b0);
      if (jstkPress === 1'b1) begin
        seen = 1;
        p0 = int'(shoot_pos);
      end
    end
    check("freeze_pulse", 32'(seen), 32'd1);
    for (int i = 0; i < 8; i++) begin
      cycle(10'd100, 1'b1, 1'b1, 1'b0);
      if (ready !== 1'b1) check("freeze_pos", 32'(shoot_pos), 32'(p0));
    end

    // 6: reset during cooldown
    cycle(10'd100, 1'b0, 1'b1, 1'b1);
    check("rst_pos", 32'(shoot_pos), 32'd3);
    check("rst_cnt", 32'(fire_cnt), 32'd0);
    check("rst_ready", 32'(ready), 32'd1);
    pulses = 0;
    run(60, 10'd100, 1'b1, 1'b0);
    run(40, 10'd100, 1'b0, 1'b0);
    check("en0_nopulse", 32'(pulses), 32'd0);
    check("en0_pos", 32'(shoot_pos), 32'd3);

    // Shot counter saturation
    for (int k = 0; k < 260; k++) begin
      run(22, 10'd512, 1'b1, 1'b1);
      run(45, 10'd512, 1'b0, 1'b1);
    end
    check("cnt_sat", 32'(fire_cnt), 32'd255);

    // Randomized segments
    for (int seg = 0; seg < 150; seg++) begin
      logic [9:0] x;
      logic b, e;
      int n;
      x = pick_x();
      b = 1'($urandom_range(0, 1));
      e = ($urandom_range(0, 9) != 0);
      n = $urandom_range(1, 60);
      if ($urandom_range(0, 24) == 0) cycle(x, b, e, 1'b1);
      run(n, x, b, e);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
